// File: rtl/seg_scan_if.sv
// Display-side bundle for the 4-digit 7-segment scan driver:
// shadow-load bus in, multiplexed anode/segment drive out.
interface seg_scan_if;
  logic [15:0] bcd_in;
  logic        neg;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  busy_digit;

  modport master (
    output bcd_in, neg, load,
    input  an, seg, busy_digit
  );

  modport slave (
    input  bcd_in, neg, load,
    output an, seg, busy_digit
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit BCD 7-segment driver with blank guard per slot.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros on digits 3..1.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       resetn,
  seg_scan_if.slave  bus
);

  localparam logic [15:0] TC = 16'(SCAN_DIV - 1);
  localparam logic [15:0] BL = 16'(BLANK_CYC);

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_E    = 7'b0000110;

  logic [15:0] shadow_q;
  logic        neg_q;
  logic [15:0] cnt_q;
  logic [1:0]  idx_q;
  logic [3:0]  an_q;
  logic [6:0]  seg_q;

  logic [3:0]  nib;
  logic        lz_blank;
  logic [3:0]  an_d;
  logic [6:0]  seg_d;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  assign nib = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [3:1] zero;

  assign zero[3] = shadow_q[15:12] == 4'd0;
  assign zero[2] = shadow_q[11:8]  == 4'd0;
  assign zero[1] = shadow_q[7:4]   == 4'd0;

  // A digit blanks only if it and every higher digit are zero.
  always_comb begin
    lz_blank = 1'b0;
    unique case (1'b1)
      idx_q == 2'd3: lz_blank = zero[3];
      idx_q == 2'd2: lz_blank = &zero[3:2];
      idx_q == 2'd1: lz_blank = &zero[3:1];
      default:       lz_blank = 1'b0;
    endcase
  end
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = dec(nib);
    if (cnt_q < BL) begin
      an_d  = 4'b1111;
      seg_d = SEG_OFF;
    end else if (idx_q == 2'd3 && neg_q) begin
      seg_d = SEG_DASH;
    end else if (lz_blank) begin
      seg_d = SEG_OFF;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shadow_q <= 16'h0000;
      neg_q    <= 1'b0;
    end else if (bus.load) begin
      shadow_q <= bus.bcd_in;
      neg_q    <= bus.neg;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 16'd0;
      idx_q <= 2'd0;
    end else if (cnt_q == TC) begin
      cnt_q <= 16'd0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.busy_digit = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver at SCAN_DIV=4, BLANK_CYC=1.
// Expectations follow SEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_scan_driver;

  logic clk;
  logic resetn;
  int   tests_run;
  int   failed;

  seg_scan_if bus();

  seg_scan_driver #(
    .SCAN_DIV  (4),
    .BLANK_CYC (1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0000010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] S8   = 7'b0000000;
  localparam logic [6:0] S9   = 7'b0010000;
  localparam logic [6:0] SE   = 7'b0000110;
  localparam logic [6:0] SDSH = 7'b0111111;
  localparam logic [6:0] SOFF = 7'b1111111;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = SOFF;
`else
  localparam logic [6:0] LZ = S0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [15:0] v, input logic n);
    @(negedge clk);
    bus.bcd_in = v;
    bus.neg    = n;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load   = 1'b0;
  endtask

  task automatic wait_digit(input logic [1:0] d, output logic [6:0] s);
    logic [3:0] want;
    bit hit;
    want = ~(4'b0001 << d);
    hit  = 1'b0;
    s    = 'x;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (bus.an == want) begin
        hit = 1'b1;
        s   = bus.seg;
      end
    end
    if (!hit) begin
      tests_run++;
      failed++;
      $display("FAIL wait_digit%0d: an=%b never seen in 40 cycles",
               d, want);
    end
  endtask

  task automatic test_reset;
    resetn     = 1'b0;
    bus.load   = 1'b0;
    bus.neg    = 1'b0;
    bus.bcd_in = 16'h0000;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1111) begin
      failed++;
      $display("FAIL reset_an: got %b want 1111", bus.an);
    end
    tests_run++;
    if (bus.seg !== SOFF) begin
      failed++;
      $display("FAIL reset_seg: got %b want %b", bus.seg, SOFF);
    end
    tests_run++;
    if (bus.busy_digit !== 2'd0) begin
      failed++;
      $display("FAIL reset_busy: got %0d want 0", bus.busy_digit);
    end
  endtask

  // Release reset and load 1234 together; trace every output cycle.
  task automatic test_scan_sequence;
    logic [6:0] tbl [4];
    logic [3:0] ea;
    logic [6:0] es;
    logic [1:0] eb;
    int k, p;
    tbl[0] = S4; tbl[1] = S3; tbl[2] = S2; tbl[3] = S1;
    resetn     = 1'b1;
    bus.bcd_in = 16'h1234;
    bus.neg    = 1'b0;
    bus.load   = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      k  = (n - 1) / 4;
      p  = (n - 1) % 4;
      eb = 2'((n / 4) % 4);
      ea = (p == 0) ? 4'b1111 : ~(4'b0001 << k);
      es = (p == 0) ? SOFF : tbl[k];
      tests_run++;
      if (bus.an !== ea || bus.seg !== es) begin
        failed++;
        $display("FAIL scan_c%0d: an=%b seg=%b want an=%b seg=%b",
                 n, bus.an, bus.seg, ea, es);
      end
      tests_run++;
      if (bus.busy_digit !== eb) begin
        failed++;
        $display("FAIL scan_busy_c%0d: got %0d want %0d",
                 n, bus.busy_digit, eb);
      end
    end
  endtask

  task automatic test_pattern(input string nm, input logic [15:0] v,
                              input logic n, input logic [6:0] e3,
                              input logic [6:0] e2, input logic [6:0] e1,
                              input logic [6:0] e0);
    logic [6:0] exp_s [4];
    logic [6:0] s;
    exp_s[0] = e0; exp_s[1] = e1; exp_s[2] = e2; exp_s[3] = e3;
    do_load(v, n);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      wait_digit(2'(d), s);
      tests_run++;
      if (s !== exp_s[d]) begin
        failed++;
        $display("FAIL %s_d%0d: seg=%b want %b", nm, d, s, exp_s[d]);
      end
    end
  endtask

  task automatic test_decode;
    test_pattern("p0007", 16'h0007, 1'b0, LZ,   LZ, LZ, S7);
    test_pattern("p0042n", 16'h0042, 1'b1, SDSH, LZ, S4, S2);
    test_pattern("p00AF", 16'h00AF, 1'b0, LZ,   LZ, SE, SE);
    test_pattern("p5678", 16'h5678, 1'b0, S5,   S6, S7, S8);
    test_pattern("p9000", 16'h9000, 1'b0, S9,   S0, S0, S0);
    test_pattern("p0305", 16'h0305, 1'b0, LZ,   S3, S0, S5);
    test_pattern("p0000", 16'h0000, 1'b0, LZ,   LZ, LZ, S0);
    test_pattern("pB000n", 16'hB000, 1'b1, SDSH, S0, S0, S0);
  endtask

  // Wrap edge is the 4th posedge after release; load on that edge.
  task automatic test_load_on_wrap;
    resetn = 1'b0;
    @(negedge clk);
    resetn     = 1'b1;
    bus.bcd_in = 16'h1111;
    bus.neg    = 1'b0;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (2) @(negedge clk);
    bus.bcd_in = 16'h2222;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    tests_run++;
    if (bus.an !== 4'b1110 || bus.seg !== S1) begin
      failed++;
      $display("FAIL wrap_old: an=%b seg=%b want an=1110 seg=%b",
               bus.an, bus.seg, S1);
    end
    tests_run++;
    if (bus.busy_digit !== 2'd1) begin
      failed++;
      $display("FAIL wrap_idx: got %0d want 1", bus.busy_digit);
    end
    @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1111 || bus.seg !== SOFF) begin
      failed++;
      $display("FAIL wrap_blank: an=%b seg=%b want 1111/%b",
               bus.an, bus.seg, SOFF);
    end
    @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1101 || bus.seg !== S2) begin
      failed++;
      $display("FAIL wrap_new: an=%b seg=%b want an=1101 seg=%b",
               bus.an, bus.seg, S2);
    end
  endtask

  task automatic test_no_load;
    logic [6:0] s;
    bus.bcd_in = 16'h8888;
    bus.neg    = 1'b1;
    repeat (8) @(negedge clk);
    wait_digit(2'd3, s);
    tests_run++;
    if (s !== S2) begin
      failed++;
      $display("FAIL noload_d3: seg=%b want %b", s, S2);
    end
    wait_digit(2'd1, s);
    tests_run++;
    if (s !== S2) begin
      failed++;
      $display("FAIL noload_d1: seg=%b want %b", s, S2);
    end
  endtask

  task automatic test_hold_load;
    logic [6:0] s;
    @(negedge clk);
    bus.neg    = 1'b0;
    bus.bcd_in = 16'h3333;
    bus.load   = 1'b1;
    @(negedge clk);
    bus.bcd_in = 16'h4444;
    @(negedge clk);
    bus.bcd_in = 16'h5555;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.bcd_in = 16'h6666;
    @(negedge clk);
    wait_digit(2'd0, s);
    tests_run++;
    if (s !== S5) begin
      failed++;
      $display("FAIL hold_d0: seg=%b want %b", s, S5);
    end
    wait_digit(2'd2, s);
    tests_run++;
    if (s !== S5) begin
      failed++;
      $display("FAIL hold_d2: seg=%b want %b", s, S5);
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [6:0] s;
    do_load(16'h0987, 1'b1);
    wait_digit(2'd2, s);
    resetn = 1'b0;
    #1;
    tests_run++;
    if (bus.an !== 4'b1111 || bus.seg !== SOFF) begin
      failed++;
      $display("FAIL midrst_out: an=%b seg=%b want 1111/%b",
               bus.an, bus.seg, SOFF);
    end
    tests_run++;
    if (bus.busy_digit !== 2'd0) begin
      failed++;
      $display("FAIL midrst_busy: got %0d want 0", bus.busy_digit);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1111 || bus.seg !== SOFF) begin
      failed++;
      $display("FAIL midrst_blank: an=%b seg=%b want 1111/%b",
               bus.an, bus.seg, SOFF);
    end
    @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1110 || bus.seg !== S0) begin
      failed++;
      $display("FAIL midrst_d0: an=%b seg=%b want 1110/%b",
               bus.an, bus.seg, S0);
    end
    wait_digit(2'd3, s);
    tests_run++;
    if (s !== LZ) begin
      failed++;
      $display("FAIL midrst_d3: seg=%b want %b", s, LZ);
    end
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    test_reset;
    test_scan_sequence;
    test_decode;
    test_load_on_wrap;
    test_no_load;
    test_hold_load;
    test_reset_mid_scan;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles each digit stays selected (legal range 2..65535).
REQ-002 SHALL have parameter BLANK_CYC, default 16: cycles at the start of each digit slot with all anodes off (anti-ghosting); legal range 0..SCAN_DIV-1.
REQ-003 SHALL have port clk, input, 1: system clock, rising-edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port bcd_in, input, 16: four BCD digits from the display mux; [3:0] is the least significant digit.
REQ-006 SHALL have port neg, input, 1: result-is-negative flag from the ALU special signal.
REQ-007 SHALL have port load, input, 1: one-cycle strobe that captures bcd_in and neg.
REQ-008 SHALL have port an, output, 4: digit anodes, active-low; an[0] drives the rightmost digit.
REQ-009 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port busy_digit, output, 2: index of the digit currently selected.

Function
REQ-011 SHALL latch bcd_in and neg into shadow registers on any rising edge with load=1; all display output SHALL come from the shadow registers only (no tearing).
REQ-012 SHALL use a prescaler that counts 0..SCAN_DIV-1; at terminal count it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-013 an and seg SHALL be registered and SHALL reflect the prescaler and index values of the previous cycle (1-cycle latency).
REQ-014 While prescaler < BLANK_CYC, an SHALL be 4'b1111 and seg SHALL be 7'b1111111; otherwise exactly one anode SHALL be low, an[index].
REQ-015 Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-016 Nibble values A-F SHALL display 'E' (0000110).
REQ-017 When shadow neg=1, digit 3 SHALL display '-' (0111111) regardless of its nibble; displayable range is -999..-1.
REQ-018 If load coincides with a prescaler wrap, the new shadow value SHALL appear on the next registered output; the scan position is unaffected.
REQ-019 load held high for several cycles SHALL re-capture every cycle; the last captured value wins.
REQ-020 busy_digit SHALL equal the internal index (unregistered from the index flop).

Reset
REQ-021 resetn=0 SHALL asynchronously force shadow data 16'h0000, shadow neg 0, prescaler 0, index 0, an=4'b1111, seg=7'b1111111.
REQ-022 Deassertion mid-scan SHALL restart the scan at digit 0, with the blank interval first.

Configuration
REQ-023 Macro SEG_LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking.
REQ-024 With the macro defined, digits 3..1 SHALL be blank (seg=1111111, anode still pulsed) when they and all more significant digits are 0; digit 0 SHALL never blank; digit 3 SHALL still show '-' when neg=1.
REQ-025 Without the macro, every digit SHALL show its decoded value (REQ-015..017).

Verification (SCAN_DIV=4, BLANK_CYC=1)
REQ-026 Reset, load 16'h1234 neg=0 -> an cycles 1110,1101,1011,0111 with seg 0011001,0110000,0100100,1111001, each preceded by one all-off cycle.
REQ-027 Load 16'h0007 with macro defined -> digits 3..1 seg=1111111, digit 0 seg=1111000; without macro digits 3..1 seg=1000000.
REQ-028 Load 16'h0042 neg=1 -> digit 3 seg=0111111, digit 0 seg=0100100; with macro, digit 2 blank and digit 1 seg=0011001.
REQ-029 Load 16'h00AF -> digits 1 and 0 seg=0000110.
REQ-030 Change bcd_in without load -> display unchanged; load asserted on the wrap cycle -> new value visible on the next output cycle.
REQ-031 resetn pulled low during digit 2 -> an=1111 and seg=1111111 immediately; after release the scan resumes at digit 0 showing 0.
